// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: reset and lock supervisor for the system PLL.
// It drives the PLL's reset and synchronises the PLL's asynchronous lock output
// into clk. It releases sys_reset only after lock has stayed high for
// STABLE_CYCLES consecutive cycles. If lock drops, the sequence runs again.
//
// Optional feature macro: PLL_RETRY_LIMIT_EN. When it is defined, the block
// stops in FAILED after MAX_RETRIES lock timeouts and holds the PLL in reset.
//
// Ports:
//   clk             free-running reference clock (not PLL-derived)
//   reset           synchronous, active-high
//   pll_locked      PLL lock indication, asynchronous to clk
//   restart         single-cycle request to re-run the full sequence
//   pll_rst         PLL areset, active-high
//   sys_reset       system reset, active-high; low only in RUN
//   ready           high only in RUN
//   retry_count     lock timeouts since reset/restart, saturating at 15
//   lock_lost_count lock losses while in RUN, saturating at 255
//   pll_failed      high in FAILED; constant 0 without the macro
module pll_reset_sequencer #(
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [3:0] retry_count,
    output logic [7:0] lock_lost_count,
    output logic       pll_failed
);

    localparam int unsigned MAX_AB    = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_ABC   = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int unsigned MAX_PARAM = (MAX_ABC > MAX_RETRIES) ? MAX_ABC : MAX_RETRIES;
    localparam int unsigned CNT_W     = ($clog2(MAX_PARAM) < 1) ? 1 : $clog2(MAX_PARAM);

    typedef enum logic [2:0] {
        ST_PLL_RESET,
        ST_WAIT_LOCK,
        ST_STABILIZE,
`ifdef PLL_RETRY_LIMIT_EN
        ST_RUN,
        ST_FAILED
`else
        ST_RUN
`endif
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [3:0]         retry_next;
    logic [3:0]         retry_inc;
    logic [7:0]         lost_next;
    logic               pll_rst_next;
    logic               ready_next;
    logic               sync_1;
    logic               locked_s;

    // Two-flop synchroniser for the asynchronous lock signal
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1   <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_1   <= pll_locked;
            locked_s <= sync_1;
        end
    end

    // Next-state, counter and statistics logic
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        retry_next = retry_count;
        lost_next  = lock_lost_count;
        retry_inc  = (retry_count == 4'hF) ? retry_count : retry_count + 4'd1;

        case (state)
            ST_PLL_RESET: begin
                cnt_next = cnt + CNT_W'(1);
                if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
                    state_next = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                cnt_next = cnt + CNT_W'(1);
                if (locked_s) begin
                    state_next = ST_STABILIZE;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retry_next = retry_inc;
`ifdef PLL_RETRY_LIMIT_EN
                    state_next = (retry_inc >= 4'(MAX_RETRIES)) ? ST_FAILED : ST_PLL_RESET;
`else
                    state_next = ST_PLL_RESET;
`endif
                end
            end
            ST_STABILIZE: begin
                cnt_next = cnt + CNT_W'(1);
                if (!locked_s) begin
                    state_next = ST_WAIT_LOCK;
                end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    lost_next  = (lock_lost_count == 8'hFF) ? lock_lost_count
                                                           : lock_lost_count + 8'd1;
                    state_next = ST_PLL_RESET;
                end
            end
`ifdef PLL_RETRY_LIMIT_EN
            ST_FAILED: begin
                state_next = ST_FAILED;
            end
`endif
            default: begin
                state_next = ST_PLL_RESET;
            end
        endcase

        // restart overrides every transition; a lock loss seen on the same edge is still counted
        if (restart) begin
            state_next = ST_PLL_RESET;
            retry_next = 4'd0;
        end

        // Restart clears the counter even when the block is already in PLL_RESET
        if (restart || (state_next != state)) begin
            cnt_next = '0;
        end

        pll_rst_next = (state_next == ST_PLL_RESET);
`ifdef PLL_RETRY_LIMIT_EN
        pll_rst_next = pll_rst_next || (state_next == ST_FAILED);
`endif
        ready_next = (state_next == ST_RUN);
    end

    // State register and registered outputs, updated on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_PLL_RESET;
            cnt             <= '0;
            retry_count     <= 4'd0;
            lock_lost_count <= 8'd0;
            pll_rst         <= 1'b1;
            sys_reset       <= 1'b1;
            ready           <= 1'b0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            retry_count     <= retry_next;
            lock_lost_count <= lost_next;
            pll_rst         <= pll_rst_next;
            sys_reset       <= !ready_next;
            ready           <= ready_next;
        end
    end

`ifdef PLL_RETRY_LIMIT_EN
    // Registered failure flag
    always_ff @(posedge clk) begin
        if (reset) begin
            pll_failed <= 1'b0;
        end else begin
            pll_failed <= (state_next == ST_FAILED);
        end
    end
`else
    assign pll_failed = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer. A reference model predicts every edge and
// queues the expected outputs; a separate monitor compares them with the DUT.
module tb_pll_reset_sequencer;

    localparam int RC = 4;
    localparam int LT = 32;
    localparam int SC = 8;
    localparam int MR = 2;
`ifdef PLL_RETRY_LIMIT_EN
    localparam bit RETRY_LIMIT = 1'b1;
`else
    localparam bit RETRY_LIMIT = 1'b0;
`endif

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_RUN  = 3;
    localparam int P_FAIL = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic [3:0] retry_count;
    logic [7:0] lock_lost_count;
    logic       pll_failed;

    int checks   = 0;
    int failures = 0;

    pll_reset_sequencer #(
        .RESET_CYCLES (RC),
        .LOCK_TIMEOUT (LT),
        .STABLE_CYCLES(SC),
        .MAX_RETRIES  (MR)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pll_locked     (pll_locked),
        .restart        (restart),
        .pll_rst        (pll_rst),
        .sys_reset      (sys_reset),
        .ready          (ready),
        .retry_count    (retry_count),
        .lock_lost_count(lock_lost_count),
        .pll_failed     (pll_failed)
    );

    always #5 clk = ~clk;

    // Expected output word: {pll_rst, sys_reset, ready, pll_failed, retry[3:0], lost[7:0]}
    logic [15:0] exp_q[$];

    // Reference model: phases with entry timestamps instead of a counter
    int cyc     = 0;
    int ph      = P_RST;
    int entered = 1;
    int m_retry = 0;
    int m_lost  = 0;
    bit hist[$] = '{1'b0, 1'b0};

    always @(posedge clk) begin : ref_model
        int elapsed;
        int nxt;
        bit ls;
        bit tmo;
        logic [15:0] e;
        cyc = cyc + 1;
        if (reset) begin
            ph      = P_RST;
            entered = cyc + 1;
            m_retry = 0;
            m_lost  = 0;
            hist    = '{1'b0, 1'b0};
        end else begin
            ls = hist.pop_front();
            hist.push_back(pll_locked);
            elapsed = cyc - entered;
            nxt     = ph;
            tmo     = 1'b0;
            case (ph)
                P_RST:  if (elapsed == RC - 1) nxt = P_WAIT;
                P_WAIT: begin
                    if (ls) nxt = P_STAB;
                    else if (elapsed == LT - 1) tmo = 1'b1;
                end
                P_STAB: begin
                    if (!ls) nxt = P_WAIT;
                    else if (elapsed == SC - 1) nxt = P_RUN;
                end
                P_RUN: begin
                    if (!ls) begin
                        m_lost = (m_lost < 255) ? m_lost + 1 : 255;
                        nxt    = P_RST;
                    end
                end
                default: ;
            endcase
            if (restart) begin
                nxt     = P_RST;
                m_retry = 0;
            end else if (tmo) begin
                m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                nxt     = (RETRY_LIMIT && m_retry >= MR) ? P_FAIL : P_RST;
            end
            if (restart || nxt != ph) entered = cyc + 1;
            ph = nxt;
        end
        e[15]   = (ph == P_RST) || (ph == P_FAIL);
        e[14]   = (ph != P_RUN);
        e[13]   = (ph == P_RUN);
        e[12]   = (ph == P_FAIL);
        e[11:8] = 4'(m_retry);
        e[7:0]  = 8'(m_lost);
        exp_q.push_back(e);
    end

    // Monitor: compares the DUT with the oldest prediction just after each edge
    always @(posedge clk) begin : monitor
        logic [15:0] e;
        logic [15:0] g;
        #1;
        checks = checks + 1;
        g = {pll_rst, sys_reset, ready, pll_failed, retry_count, lock_lost_count};
        if (exp_q.size() == 0) begin
            failures = failures + 1;
            $display("FAIL scoreboard_underflow edge %0d", cyc);
        end else begin
            e = exp_q.pop_front();
            if (g !== e) begin
                failures = failures + 1;
                $display("FAIL scoreboard edge %0d: got rst=%b sys=%b rdy=%b fail=%b retry=%0d lost=%0d, expected rst=%b sys=%b rdy=%b fail=%b retry=%0d lost=%0d",
                         cyc, g[15], g[14], g[13], g[12], g[11:8], g[7:0],
                         e[15], e[14], e[13], e[12], e[11:8], e[7:0]);
            end
        end
    end

    task automatic chk(input string name, input int got, input int expv);
        checks = checks + 1;
        if (got != expv) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds reset for n edges; the edge after return is edge 1 with reset low
    task automatic do_reset(input int n, input logic lk);
        reset      = 1'b1;
        restart    = 1'b0;
        pll_locked = lk;
        cycles(n);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        restart    = 1'b0;
        pll_locked = 1'b1;

        // Reset values and clean bring-up with lock held high
        do_reset(3, 1'b1);
        chk("reset_pll_rst", int'(pll_rst), 1);
        chk("reset_sys_reset", int'(sys_reset), 1);
        chk("reset_ready", int'(ready), 0);
        chk("reset_failed", int'(pll_failed), 0);
        cycles(3);
        chk("pll_rst_edge3", int'(pll_rst), 1);
        cycles(1);
        chk("pll_rst_edge4", int'(pll_rst), 0);
        cycles(8);
        chk("ready_edge12", int'(ready), 0);
        cycles(1);
        chk("ready_edge13", int'(ready), 1);
        chk("sys_reset_edge13", int'(sys_reset), 0);

        // Lock loss in RUN: sys_reset rises three edges later
        pll_locked = 1'b0;
        cycles(2);
        chk("loss_sys_reset_edge2", int'(sys_reset), 0);
        cycles(1);
        chk("loss_sys_reset_edge3", int'(sys_reset), 1);
        chk("loss_count", int'(lock_lost_count), 1);
        chk("loss_pll_rst", int'(pll_rst), 1);
        pll_locked = 1'b1;
        cycles(30);
        chk("relock_ready", int'(ready), 1);

        // Late lock with a three-cycle dropout during STABILIZE
        do_reset(2, 1'b0);
        cycles(19);
        pll_locked = 1'b1;
        cycles(4);
        pll_locked = 1'b0;
        cycles(3);
        pll_locked = 1'b1;
        cycles(20);
        chk("dropout_ready", int'(ready), 1);
        chk("dropout_retry", int'(retry_count), 0);

        // Lock never arrives: retry limit or saturation depending on build
        do_reset(2, 1'b0);
        cycles(600);
        chk("nolock_retry", int'(retry_count), RETRY_LIMIT ? MR : 15);
        chk("nolock_failed", int'(pll_failed), RETRY_LIMIT ? 1 : 0);
        restart = 1'b1;
        cycles(1);
        restart = 1'b0;
        chk("restart_retry", int'(retry_count), 0);
        chk("restart_pll_rst", int'(pll_rst), 1);
        chk("restart_failed", int'(pll_failed), 0);
        pll_locked = 1'b1;
        cycles(30);
        chk("restart_ready", int'(ready), 1);

        // restart on the timeout edge: no increment
        do_reset(2, 1'b0);
        cycles(35);
        restart = 1'b1;
        cycles(1);
        restart = 1'b0;
        chk("tmo_restart_retry", int'(retry_count), 0);
        chk("tmo_restart_pll_rst", int'(pll_rst), 1);
        cycles(4);
        chk("tmo_restart_wait", int'(pll_rst), 0);

        // Randomised lock behaviour with occasional restart and reset
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) pll_locked = ~pll_locked;
            restart = ($urandom_range(0, 149) == 0);
            reset   = ($urandom_range(0, 599) == 0);
            cycles(1);
        end
        restart = 1'b0;
        reset   = 1'b0;
        cycles(3);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset and lock supervisor for the system PLL. It drives the PLL's asynchronous reset, watches its asynchronous `locked` output, and releases the system reset only after lock has been stable for a programmed interval. On lock loss it re-runs the sequence. It runs on the free-running board reference clock, upstream of every `sys_clk` consumer. `sys_reset` is re-synchronised into `sys_clk` by its consumers.

## Interface
- `RESET_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥2).
- `LOCK_TIMEOUT`, 65536: cycles to wait for lock before retrying (≥2).
- `STABLE_CYCLES`, 1024: consecutive locked cycles required before release (≥1).
- `MAX_RETRIES`, 3: failed attempts before `FAILED` (used only with `PLL_RETRY_LIMIT_EN`; 1..15).

Ports (counter widths are `$clog2` of the largest parameter):
- `clk` input 1: free-running reference clock; not PLL-derived.
- `reset` input 1: synchronous, active-high.
- `pll_locked` input 1: PLL lock, asynchronous to `clk`.
- `restart` input 1: single-cycle request to re-run the full sequence.
- `pll_rst` output 1: PLL areset, active-high.
- `sys_reset` output 1: system reset, active-high.
- `ready` output 1: high only in `RUN`.
- `retry_count` output 4: timeouts since reset/restart, saturates at 15.
- `lock_lost_count` output 8: lock losses while in `RUN`, saturates at 255.
- `pll_failed` output 1: high in `FAILED`; tied 0 without the macro.

## Operation
- `pll_locked` passes through a 2-flop synchroniser to give `locked_s`. Synchroniser flops reset to 0.
- States: `PLL_RESET`, `WAIT_LOCK`, `STABILIZE`, `RUN`, `FAILED`. One shared cycle counter is cleared on every state change.
- `PLL_RESET`: `pll_rst`=1. When counter == `RESET_CYCLES`-1, go to `WAIT_LOCK`.
- `WAIT_LOCK`: `pll_rst`=0.
  - If `locked_s`, go to `STABILIZE`.
  - Else if counter == `LOCK_TIMEOUT`-1: increment `retry_count`, then go to `PLL_RESET`. With the macro, go to `FAILED` instead when the new count ≥ `MAX_RETRIES`.
- `STABILIZE`:
  - If `!locked_s`, return to `WAIT_LOCK` (counter cleared, no retry increment).
  - Else when counter == `STABLE_CYCLES`-1, go to `RUN`.
- `RUN`: `sys_reset`=0, `ready`=1. On `!locked_s`, increment `lock_lost_count` and go to `PLL_RESET`.
- `FAILED`: `pll_rst`=1, `sys_reset`=1. The block stays here until `reset` or `restart`.
- `restart` has priority over every transition. In any state it goes to `PLL_RESET` and clears `retry_count`. It does not clear `lock_lost_count`.
- `sys_reset` = 1 and `ready` = 0 in every state except `RUN`.
- All outputs are registered and change on the same edge as the state register.

## Timing
- Reset values: state `PLL_RESET`, `pll_rst`=1, `sys_reset`=1, `ready`=0, `pll_failed`=0, counters 0.
- `reset` asserted mid-sequence returns to these values on the next edge, regardless of `pll_locked`.
- With `pll_locked` steady high, `ready` rises `RESET_CYCLES`+1+`STABLE_CYCLES` edges after the first edge with `reset` low.
- `pll_locked` falling while in `RUN`: `sys_reset` rises 3 edges later (2 synchroniser edges + 1 state edge).
- Lock pulses shorter than 2 `clk` periods may be missed. This is acceptable.
- `restart` and a timeout on the same edge: `restart` wins, no increment.
- Lock loss and `restart` in `RUN` on the same edge: `lock_lost_count` still increments.
- Both counters saturate; they never wrap.

## Configuration
- `PLL_RETRY_LIMIT_EN` defined: the `FAILED` state and `pll_failed` are implemented. After `MAX_RETRIES` timeouts the block parks with the PLL held in reset.
- Undefined: there is no `FAILED` state and `pll_failed` is constant 0. Retries continue indefinitely; `retry_count` still saturates at 15.

## Test plan
Bench parameters: `RESET_CYCLES`=4, `STABLE_CYCLES`=8, `LOCK_TIMEOUT`=32, `MAX_RETRIES`=2.
- Reset release with `pll_locked`=1 -> `pll_rst` low after 4 edges; `ready`=1 and `sys_reset`=0 at edge 13.
- `pll_locked` goes high at edge 20 and drops for 3 cycles during `STABILIZE` -> back to `WAIT_LOCK`; `ready` rises 1+8 edges after lock returns and has settled through the synchroniser; `retry_count`=0.
- `pll_locked` dropped in `RUN` -> `sys_reset`=1 3 edges later, `lock_lost_count`=1, `pll_rst` high for 4 cycles, then clean relock.
- `pll_locked` held 0, macro defined -> `pll_rst` pulses twice, `retry_count`=2, `pll_failed`=1 with `pll_rst`=1. `restart` -> `retry_count`=0, sequence restarts.
- Same stimulus, macro undefined -> retries continue, `retry_count` saturates at 15, `pll_failed` stays 0.
- `restart` asserted on the timeout edge -> `retry_count` unchanged at 0, state `PLL_RESET`.
